// File: rtl/multi_tick_divider_if.sv
// multi_tick_divider_if
//   Control and status bundle of the multi-channel timebase divider.
//   master : the controller. It drives enable, divisors, load strobes,
//            modes and sync, and it observes outputs and pending flags.
//   slave  : the divider itself.
//   Signals:
//     iCle       global clock enable (freezes counters/outputs when low)
//     ivDivisor  CHANNELS*WIDTH new divisors; channel k at [k*WIDTH +: WIDTH]
//     ivLoad     per-channel strobe, captures ivDivisor slice into pending
//     ivMode     per-channel mode, 0 = single-cycle pulse, 1 = square wave
//     iSync      restart of all channels
//     ovOut      per-channel registered timebase output
//     ovPending  per-channel "loaded divisor waiting for terminal count"
interface multi_tick_divider_if #(
  parameter int WIDTH    = 27,
  parameter int CHANNELS = 2
);
  logic                         iCle;
  logic [CHANNELS*WIDTH-1:0]    ivDivisor;
  logic [CHANNELS-1:0]          ivLoad;
  logic [CHANNELS-1:0]          ivMode;
  logic                         iSync;
  logic [CHANNELS-1:0]          ovOut;
  logic [CHANNELS-1:0]          ovPending;

  modport master (
    output iCle,
    output ivDivisor,
    output ivLoad,
    output ivMode,
    output iSync,
    input  ovOut,
    input  ovPending
  );

  modport slave (
    input  iCle,
    input  ivDivisor,
    input  ivLoad,
    input  ivMode,
    input  iSync,
    output ovOut,
    output ovPending
  );
endinterface

// File: rtl/multi_tick_divider.sv
// multi_tick_divider
//   CHANNELS independent programmable timebases derived from iClk. Each
//   channel counts 0..N (N = active divisor), giving a period of N+1
//   enabled cycles, and emits either a one-cycle pulse or a 50% square
//   wave. New divisors are double-buffered: a load only lands in a pending
//   register, which is promoted at the next terminal count (or at iSync),
//   so a running period is never shortened or stretched.
//   Ports:
//     iClk      system clock, rising edge
//     iReset_n  asynchronous active-low reset
//     bus       multi_tick_divider_if.slave (enable, divisors, loads,
//               modes, sync in; ovOut / ovPending out, both registered)
module multi_tick_divider #(
  parameter int WIDTH       = 27,
  parameter int CHANNELS    = 2,
  parameter int DEFAULT_DIV = 90000
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  multi_tick_divider_if.slave  bus
);

  localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE_W         = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0] out_v;
  logic [CHANNELS-1:0] pend_v;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [WIDTH-1:0] count_r;
      logic [WIDTH-1:0] active_r;
      logic [WIDTH-1:0] pend_r;
      logic             out_r;
      logic             pend_flag_r;

      logic [WIDTH-1:0] count_s;
      logic [WIDTH-1:0] active_s;
      logic [WIDTH-1:0] pend_s;
      logic             out_s;
      logic             pend_flag_s;
      logic [WIDTH-1:0] div_in_s;
      logic             terminal_s;

      assign div_in_s   = bus.ivDivisor[k*WIDTH +: WIDTH];
      // The counter never exceeds the active divisor, so equality is the
      // terminal condition; with N = all-ones the +1 wraps to 0 by itself.
      assign terminal_s = (count_r == active_r);

      // Next-state: sync first, then terminal/count (gated by iCle), then loads.
      always_comb begin
        count_s     = count_r;
        active_s    = active_r;
        pend_s      = pend_r;
        out_s       = out_r;
        pend_flag_s = pend_flag_r;

        if (bus.iSync) begin
          count_s = '0;
          out_s   = 1'b0;
          if (bus.ivLoad[k]) begin
            // A load coinciding with sync bypasses the pending stage.
            active_s    = div_in_s;
            pend_s      = div_in_s;
            pend_flag_s = 1'b0;
          end else if (pend_flag_r) begin
            active_s    = pend_r;
            pend_flag_s = 1'b0;
          end else begin
            active_s    = active_r;
          end
        end else begin
          if (bus.iCle) begin
            if (terminal_s) begin
              count_s = '0;
              if (pend_flag_r) begin
                active_s    = pend_r;
                pend_flag_s = 1'b0;
              end else begin
                active_s    = active_r;
              end
            end else begin
              count_s = count_r + ONE_W;
            end

            // Pulse mode follows the terminal flag directly, which also
            // forces the output low on a switch into pulse mode.
            if (bus.ivMode[k]) begin
              out_s = terminal_s ? ~out_r : out_r;
            end else begin
              out_s = terminal_s;
            end
          end else begin
            count_s = count_r;
          end

          // Loads are captured regardless of iCle. Placed after terminal
          // handling so a load on the terminal edge stays pending for the
          // following period.
          if (bus.ivLoad[k]) begin
            pend_s      = div_in_s;
            pend_flag_s = 1'b1;
          end else begin
            pend_s      = pend_s;
          end
        end
      end

      // Channel state registers with asynchronous reset to the default divisor.
      always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
          count_r     <= '0;
          active_r    <= DEFAULT_DIV_W;
          pend_r      <= DEFAULT_DIV_W;
          out_r       <= 1'b0;
          pend_flag_r <= 1'b0;
        end else begin
          count_r     <= count_s;
          active_r    <= active_s;
          pend_r      <= pend_s;
          out_r       <= out_s;
          pend_flag_r <= pend_flag_s;
        end
      end

      assign out_v[k]  = out_r;
      assign pend_v[k] = pend_flag_r;
    end
  endgenerate

  assign bus.ovOut     = out_v;
  assign bus.ovPending = pend_v;

endmodule

// File: tb/tb_multi_tick_divider.sv
// Testbench for multi_tick_divider: directed scenarios plus random traffic,
// every cycle's outputs checked against a countdown-based reference model
// through a scoreboard queue.
module tb_multi_tick_divider;
  localparam int W   = 8;
  localparam int CH  = 2;
  localparam int DEF = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  multi_tick_divider_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  multi_tick_divider #(.WIDTH(W), .CHANNELS(CH), .DEFAULT_DIV(DEF)) dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- reference model ----------------
  // Each channel: enabled edges left until the period ends, active and
  // pending divisors, pending flag, output level.
  int  m_left [CH];
  int  m_act  [CH];
  int  m_pend [CH];
  bit  m_pflag[CH];
  bit  m_out  [CH];
  logic [2*CH-1:0] exp_q[$];

  task automatic model_step();
    logic [2*CH-1:0] e;
    for (int k = 0; k < CH; k++) begin
      if (!rst_n) begin
        m_act[k] = DEF; m_pend[k] = DEF; m_pflag[k] = 1'b0; m_out[k] = 1'b0;
        m_left[k] = DEF + 1;
      end else begin
        int  dv;
        bit  ended;
        dv = int'(bus.ivDivisor[k*W +: W]);
        if (bus.iSync) begin
          m_out[k] = 1'b0;
          if (bus.ivLoad[k]) begin
            m_act[k] = dv; m_pend[k] = dv; m_pflag[k] = 1'b0;
          end else if (m_pflag[k]) begin
            m_act[k] = m_pend[k]; m_pflag[k] = 1'b0;
          end
          m_left[k] = m_act[k] + 1;
        end else begin
          ended = 1'b0;
          if (bus.iCle) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
              ended = 1'b1;
              if (m_pflag[k]) begin
                m_act[k] = m_pend[k]; m_pflag[k] = 1'b0;
              end
              m_left[k] = m_act[k] + 1;
            end
            m_out[k] = bus.ivMode[k] ? (m_out[k] ^ ended) : ended;
          end
          if (bus.ivLoad[k]) begin
            m_pend[k] = dv; m_pflag[k] = 1'b1;
          end
        end
      end
      e[k]      = m_out[k];
      e[CH + k] = m_pflag[k];
    end
    exp_q.push_back(e);
  endtask

  always begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare registered outputs shortly after each active edge.
  always begin
    logic [2*CH-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("cycle_outputs", {bus.ovPending, bus.ovOut}, e);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync_load(input int ch, input int val, input bit with_sync);
    bus.ivDivisor[ch*W +: W] = W'(val);
    bus.ivLoad[ch] = 1'b1;
    bus.iSync      = with_sync;
    @(negedge clk);
    bus.ivLoad = '0;
    bus.iSync  = 1'b0;
  endtask

  // Negedges until ovOut[ch] is seen high (limit on expiry).
  task automatic wait_rise(input int ch, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (bus.ovOut[ch]) break;
    end
  endtask

  // Length of the current run of level lvl on ovOut[ch], counting the present cycle.
  task automatic run_len(input int ch, input bit lvl, input int limit, output int n);
    n = 1;
    while (n < limit) begin
      @(negedge clk);
      if (bus.ovOut[ch] != lvl) break;
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    int n;
    bit a;
    bus.iCle = 1'b0; bus.ivDivisor = '0; bus.ivLoad = '0; bus.ivMode = '0; bus.iSync = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", bus.ovOut, 0);
    check("reset_pending", bus.ovPending, 0);
    rst_n = 1'b1;
    bus.iCle = 1'b1;
    @(negedge clk);

    // Pulse ch0 with N=4 via load+sync; ch1 keeps the default divisor.
    sync_load(0, 4, 1'b1);
    wait_rise(0, 20, n); check("pulse_first_after_sync", n, 5);
    wait_rise(0, 20, n); check("pulse_period_n4", n, 5);
    wait_rise(1, 20, n);
    wait_rise(1, 20, n); check("ch1_default_period", n, 10);

    // Square ch0 with N=3, then a 7-cycle freeze in the middle of a high phase.
    bus.ivMode[0] = 1'b1;
    sync_load(0, 3, 1'b1);
    wait_rise(0, 20, n); check("square_first_rise", n, 4);
    run_len(0, 1'b1, 20, n); check("square_high_len", n, 4);
    run_len(0, 1'b0, 20, n); check("square_low_len", n, 4);
    @(negedge clk);
    bus.iCle = 1'b0;
    repeat (7) @(negedge clk);
    check("square_freeze_hold", bus.ovOut[0], 1);
    bus.iCle = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.ovOut[0]) break;
      n++;
    end
    check("square_resume_high", n, 2);

    // Mid-period reloads: N=9, load 2 at count 3, load 6 at count 5.
    bus.ivMode[0] = 1'b0;
    sync_load(0, 9, 1'b1);
    repeat (3) @(negedge clk);
    sync_load(0, 2, 1'b0);
    @(negedge clk);
    sync_load(0, 6, 1'b0);
    check("reload_pending_set", bus.ovPending[0], 1);
    wait_rise(0, 20, n); check("reload_current_period_kept", n, 4);
    check("reload_pending_cleared", bus.ovPending[0], 0);
    wait_rise(0, 20, n); check("reload_new_period", n, 7);

    // Load on the terminal edge itself (N=4, load 1 at count 4).
    sync_load(0, 4, 1'b1);
    repeat (4) @(negedge clk);
    sync_load(0, 1, 1'b0);
    check("term_load_pending", bus.ovPending[0], 1);
    wait_rise(0, 20, n); check("term_load_period_unchanged", n, 5);
    wait_rise(0, 20, n); check("term_load_new_period", n, 2);

    // N=0: constant pulse output, then per-cycle toggling in square mode.
    sync_load(0, 0, 1'b1);
    wait_rise(0, 5, n); check("n0_first", n, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("n0_pulse_const", bus.ovOut[0], 1);
    end
    bus.ivMode[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a = bus.ovOut[0];
      @(negedge clk);
      check("n0_square_toggle", bus.ovOut[0], !a);
    end

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", bus.ovOut, 0);
    check("async_reset_pending", bus.ovPending, 0);
    bus.ivMode = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise(0, 20, n); check("reset_restores_default", n, 10);

    // ch1 at count 50 of a long period: sync with load 7.
    sync_load(1, 100, 1'b1);
    repeat (50) @(negedge clk);
    sync_load(1, 7, 1'b1);
    check("sync_load_out_cleared", bus.ovOut[1], 0);
    check("sync_load_no_pending", bus.ovPending[1], 0);
    wait_rise(1, 20, n); check("sync_load_first_pulse", n, 8);

    // All-ones divisor: counter reaches 255 and returns to 0.
    sync_load(0, 255, 1'b1);
    wait_rise(0, 300, n); check("max_div_first", n, 256);
    wait_rise(0, 300, n); check("max_div_period", n, 256);

    // Random traffic, checked cycle by cycle through the scoreboard.
    for (int i = 0; i < 2000; i++) begin
      bus.iCle = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < CH; k++) begin
        bus.ivDivisor[k*W +: W] = W'($urandom_range(0, 11));
        bus.ivLoad[k] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 40) == 0) bus.ivMode[k] = ~bus.ivMode[k];
      end
      bus.iSync = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    bus.ivLoad = '0;
    bus.iSync  = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
